// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep sequencer: FSM states, half-word
// select encodings and default counter widths.
package dds_pkg;

   localparam int GAP_W_DEF   = 8;
   localparam int DWELL_W_DEF = 16;
   localparam int CNT_W_DEF   = 10;

   // choice output encoding toward the config stage
   localparam logic CHOICE_HI = 1'b1;
   localparam logic CHOICE_LO = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LD_HI  = 3'd1,
      GAP_HI = 3'd2,
      LD_LO  = 3'd3,
      GAP_LO = 3'd4,
      DWELL  = 3'd5,
      FIN    = 3'd6
   } state_t;

endpackage

// File: rtl/dds_dncount.sv
// Loadable down-counter with a zero flag. Load has priority over
// decrement, and decrement saturates at zero.
module dds_dncount #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] value,
   output logic [W-1:0] count,
   output logic         zero
);

   // count register: load wins, otherwise count down toward zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (load)
         count <= value;
      else if (en && (count != '0))
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dds_sweep_seq.sv
// Frequency-sweep sequencer. Each 32-bit tuning word is sent as a high half
// and then a low half. Each half gets a one-cycle load strobe followed by a
// guard interval. Each point is held for a dwell time before the next word.
module dds_sweep_seq
   import dds_pkg::*;
#(
   parameter int GAP_W   = GAP_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [31:0]        fstart,
   input  logic [31:0]        fstep,
   input  logic [CNT_W-1:0]   npoints,
   input  logic [GAP_W-1:0]   gap,
   input  logic [DWELL_W-1:0] dwell,
   output logic [15:0]        datain,
   output logic               choice,
   output logic               load,
   output logic               busy,
   output logic               point_tick,
   output logic               done
);

   state_t             state;
   logic [31:0]        word;
   logic [31:0]        step_r;
   logic [CNT_W-1:0]   pts;
   logic [GAP_W-1:0]   gap_r;
   logic [DWELL_W-1:0] dwell_r;
   logic               abort_pend;

   logic [31:0]        nxt_word;
   logic [GAP_W-1:0]   g_ld_val;
   logic [DWELL_W-1:0] d_ld_val;
   logic [GAP_W-1:0]   g_count;
   logic [DWELL_W-1:0] d_count;
   logic               g_zero;
   logic               d_zero;
   logic               g_load;
   logic               g_en;
   logic               d_load;
   logic               d_en;

   // Modulo-2^32 step. A downward sweep through zero wraps silently.
   assign nxt_word = word + step_r;

   // Counters are loaded with length-1 and the phase ends on the zero cycle,
   // so a phase lasts max(len,1) cycles. A length of 0 behaves like 1.
   assign g_ld_val = (gap_r   == '0) ? '0 : gap_r   - 1'b1;
   assign d_ld_val = (dwell_r == '0) ? '0 : dwell_r - 1'b1;

   assign g_load = (state == LD_HI) || (state == LD_LO);
   assign g_en   = (state == GAP_HI) || (state == GAP_LO);
   assign d_load = (state == GAP_LO) && g_zero;
   assign d_en   = (state == DWELL);

   dds_dncount #(.W(GAP_W)) u_guard (
      .clk   (clk),
      .reset (reset),
      .load  (g_load),
      .en    (g_en),
      .value (g_ld_val),
      .count (g_count),
      .zero  (g_zero)
   );

   dds_dncount #(.W(DWELL_W)) u_dwell (
      .clk   (clk),
      .reset (reset),
      .load  (d_load),
      .en    (d_en),
      .value (d_ld_val),
      .count (d_count),
      .zero  (d_zero)
   );

   // Sweep FSM. All outputs are registered and change together with the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         word       <= '0;
         step_r     <= '0;
         pts        <= '0;
         gap_r      <= '0;
         dwell_r    <= '0;
         abort_pend <= 1'b0;
         datain     <= '0;
         choice     <= 1'b0;
         load       <= 1'b0;
         busy       <= 1'b0;
         point_tick <= 1'b0;
         done       <= 1'b0;
      end else begin
         load       <= 1'b0;
         point_tick <= 1'b0;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               // abort is ignored here, and start wins over abort
               if (start) begin
                  word       <= fstart;
                  step_r     <= fstep;
                  gap_r      <= gap;
                  dwell_r    <= dwell;
                  pts        <= (npoints == '0) ? CNT_W'(1) : npoints;
                  abort_pend <= 1'b0;
                  datain     <= fstart[31:16];
                  choice     <= CHOICE_HI;
                  load       <= 1'b1;
                  busy       <= 1'b1;
                  state      <= LD_HI;
               end
            end
            LD_HI: state <= GAP_HI;
            GAP_HI: begin
               if (g_zero) begin
                  // An abort here is deferred so the low half still goes out
                  // and the DDS never holds a mixed word.
                  if (abort) abort_pend <= 1'b1;
                  datain     <= word[15:0];
                  choice     <= CHOICE_LO;
                  load       <= 1'b1;
                  point_tick <= 1'b1;
                  state      <= LD_LO;
               end
            end
            LD_LO: state <= GAP_LO;
            GAP_LO: begin
               if (g_zero) begin
                  if (abort || abort_pend) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     state <= DWELL;
                  end
               end
            end
            DWELL: begin
               if (d_zero) begin
                  if (abort || (pts == CNT_W'(1))) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     pts    <= pts - 1'b1;
                     word   <= nxt_word;
                     datain <= nxt_word[31:16];
                     choice <= CHOICE_HI;
                     load   <= 1'b1;
                     state  <= LD_HI;
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_sweep_seq.sv
// Directed bench for dds_sweep_seq. A negedge monitor logs every load strobe
// as {choice,datain} with its cycle number. Each test then checks that log
// against hand-computed values.
module tb_dds_sweep_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] fstart = '0;
   logic [31:0] fstep = '0;
   logic [9:0]  npoints = '0;
   logic [7:0]  gap = '0;
   logic [15:0] dwell = '0;
   logic [15:0] datain;
   logic        choice, load, busy, point_tick, done;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;

   logic [16:0] ld_q[$];
   int          ld_cyc[$];
   int          ticks = 0;
   int          dones = 0;
   int          done_cyc = 0;

   dds_sweep_seq dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .fstart     (fstart),
      .fstep      (fstep),
      .npoints    (npoints),
      .gap        (gap),
      .dwell      (dwell),
      .datain     (datain),
      .choice     (choice),
      .load       (load),
      .busy       (busy),
      .point_tick (point_tick),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // log strobes and pulses away from the active edge
   always @(negedge clk) begin
      if (load) begin
         ld_q.push_back({choice, datain});
         ld_cyc.push_back(cyc);
      end
      if (point_tick) ticks <= ticks + 1;
      if (done) begin
         dones    <= dones + 1;
         done_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] ld_at(input int i);
      return (i < ld_q.size()) ? ld_q[i] : 17'h1ffff;
   endfunction

   function automatic int cyc_at(input int i);
      return (i < ld_cyc.size()) ? ld_cyc[i] : -1000;
   endfunction

   task automatic setup(input logic [31:0] fs, input logic [31:0] st, input logic [9:0] np,
                        input logic [7:0] g, input logic [15:0] d);
      fstart = fs; fstep = st; npoints = np; gap = g; dwell = d;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // wait for done (bounded), then check busy in FIN and after it
   task automatic wait_done(input string tag, input int limit);
      int d0;
      bit seen;
      d0 = dones;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk); #1;
         if (dones != d0) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_busy_fin"}, 32'(busy), 32'd1);
      @(negedge clk); #1;
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_loads(input string tag, input int base, input int n, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge clk); #1;
         if (ld_q.size() - base >= n) seen = 1'b1;
      end
      chk({tag, "_loads_seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, t0, d0, bad;
      logic [16:0] exp3[6];
      logic [16:0] exp4[4];

      // reset state
      #2 reset = 1'b0;
      #3;
      chk("rst_outs", 32'({datain, choice, load, busy, point_tick, done}), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // idle with no start: everything stays low
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if ({datain, choice, load, busy, point_tick, done} != '0) bad++;
      end
      chk("idle_quiet", 32'(bad), 32'd0);

      // single point, gap 3 dwell 5
      setup(32'h12345678, 32'h0, 10'd1, 8'd3, 16'd5);
      b = ld_q.size(); t0 = ticks; d0 = dones;
      pulse_start();
      wait_done("t2", 200);
      chk("t2_nld", 32'(ld_q.size() - b), 32'd2);
      chk("t2_hi", 32'(ld_at(b)), {15'd0, 1'b1, 16'h1234});
      chk("t2_lo", 32'(ld_at(b + 1)), {15'd0, 1'b0, 16'h5678});
      chk("t2_hi_lo_gap", 32'(cyc_at(b + 1) - cyc_at(b)), 32'd4);
      chk("t2_ticks", 32'(ticks - t0), 32'd1);
      chk("t2_done_lat", 32'(done_cyc - cyc_at(b)), 32'd13);
      chk("t2_ndone", 32'(dones - d0), 32'd1);

      // upward wrap through zero
      setup(32'hFFFFFFF0, 32'h10, 10'd3, 8'd2, 16'd1);
      exp3 = '{{1'b1, 16'hFFFF}, {1'b0, 16'hFFF0}, {1'b1, 16'h0000},
               {1'b0, 16'h0000}, {1'b1, 16'h0000}, {1'b0, 16'h0010}};
      b = ld_q.size(); t0 = ticks;
      pulse_start();
      wait_done("t3", 300);
      chk("t3_nld", 32'(ld_q.size() - b), 32'd6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("t3_ld%0d", i), 32'(ld_at(b + i)), 32'(exp3[i]));
      chk("t3_ticks", 32'(ticks - t0), 32'd3);

      // negative step
      setup(32'h00010000, 32'hFFFFFFFF, 10'd2, 8'd1, 16'd0);
      exp4 = '{{1'b1, 16'h0001}, {1'b0, 16'h0000}, {1'b1, 16'h0000}, {1'b0, 16'hFFFF}};
      b = ld_q.size();
      pulse_start();
      wait_done("t4", 200);
      chk("t4_nld", 32'(ld_q.size() - b), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t4_ld%0d", i), 32'(ld_at(b + i)), 32'(exp4[i]));

      // abort raised in GAP_HI of point 2 of 5
      setup(32'h11112222, 32'h00010001, 10'd5, 8'd4, 16'd2);
      b = ld_q.size(); t0 = ticks; d0 = dones;
      pulse_start();
      wait_loads("t5", b, 3, 200);
      abort = 1'b1;
      wait_done("t5", 200);
      abort = 1'b0;
      chk("t5_nld", 32'(ld_q.size() - b), 32'd4);
      chk("t5_hi2", 32'(ld_at(b + 2)), {15'd0, 1'b1, 16'h1112});
      chk("t5_lo2", 32'(ld_at(b + 3)), {15'd0, 1'b0, 16'h2223});
      chk("t5_ticks", 32'(ticks - t0), 32'd2);
      chk("t5_ndone", 32'(dones - d0), 32'd1);
      repeat (20) @(negedge clk);
      chk("t5_no_more", 32'(ld_q.size() - b), 32'd4);

      // async reset during GAP_LO, then a clean sweep
      setup(32'hDEADBEEF, 32'h1, 10'd3, 8'd5, 16'd3);
      b = ld_q.size();
      pulse_start();
      wait_loads("t6", b, 2, 200);
      @(negedge clk); #1;
      chk("t6_busy_pre", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_async_outs", 32'({datain, choice, load, busy, point_tick, done}), 32'd0);
      @(negedge clk); reset = 1'b1;
      setup(32'h0F0FA5A5, 32'h0, 10'd1, 8'd1, 16'd1);
      b = ld_q.size();
      pulse_start();
      wait_done("t6b", 100);
      chk("t6b_nld", 32'(ld_q.size() - b), 32'd2);
      chk("t6b_hi", 32'(ld_at(b)), {15'd0, 1'b1, 16'h0F0F});
      chk("t6b_lo", 32'(ld_at(b + 1)), {15'd0, 1'b0, 16'hA5A5});

      // zero gap/dwell/npoints act as 1; start while busy is ignored
      setup(32'hCAFEF00D, 32'h0, 10'd0, 8'd0, 16'd0);
      b = ld_q.size(); t0 = ticks;
      pulse_start();
      pulse_start();
      wait_done("t7", 100);
      chk("t7_nld", 32'(ld_q.size() - b), 32'd2);
      chk("t7_hi", 32'(ld_at(b)), {15'd0, 1'b1, 16'hCAFE});
      chk("t7_lo", 32'(ld_at(b + 1)), {15'd0, 1'b0, 16'hF00D});
      chk("t7_hi_lo_gap", 32'(cyc_at(b + 1) - cyc_at(b)), 32'd2);
      chk("t7_done_lat", 32'(done_cyc - cyc_at(b)), 32'd5);
      chk("t7_ticks", 32'(ticks - t0), 32'd1);

      // minimum per-point period with two points
      setup(32'h00000001, 32'h1, 10'd2, 8'd0, 16'd0);
      b = ld_q.size();
      pulse_start();
      wait_done("t8", 100);
      chk("t8_nld", 32'(ld_q.size() - b), 32'd4);
      chk("t8_period", 32'(cyc_at(b + 2) - cyc_at(b)), 32'd5);
      chk("t8_lo2", 32'(ld_at(b + 3)), {15'd0, 1'b0, 16'h0002});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
